// File: rtl/game_pkg.sv
// Shared game-flow types and default frame constants, reused by the overlays and HUD.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIVES_W = 3;

  localparam int unsigned DEF_START_LIVES  = 3;
  localparam int unsigned DEF_READY_FRAMES = 120;
  localparam int unsigned DEF_DYING_FRAMES = 90;
  localparam int unsigned DEF_END_FRAMES   = 300;
  localparam int unsigned DEF_CNT_W        = 10;

  typedef enum logic [STATE_W-1:0] {
    ST_TITLE  = 3'd0,
    ST_READY  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_DYING  = 3'd3,
    ST_WON    = 3'd4,
    ST_LOST   = 3'd5,
    ST_PAUSED = 3'd6
  } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-flow control bundle: input/collision events in, overlay and freeze controls out.
// pause_btn exists only when GAME_PAUSE_EN is defined.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic               frame_tick;
  logic               start_btn;
  logic               pdot_exist;
  logic               edot_exist;
  logic               pacman_hit;
`ifdef GAME_PAUSE_EN
  logic               pause_btn;
`endif
  logic               game_started;
  logic               freeze;
  logic               show_ready;
  logic               show_won;
  logic               show_lost;
  logic [LIVES_W-1:0] lives;
  logic [STATE_W-1:0] state_dbg;

`ifdef GAME_PAUSE_EN
  modport master (
    output frame_tick, start_btn, pdot_exist, edot_exist, pacman_hit, pause_btn,
    input  game_started, freeze, show_ready, show_won, show_lost, lives, state_dbg
  );
  modport slave (
    input  frame_tick, start_btn, pdot_exist, edot_exist, pacman_hit, pause_btn,
    output game_started, freeze, show_ready, show_won, show_lost, lives, state_dbg
  );
`else
  modport master (
    output frame_tick, start_btn, pdot_exist, edot_exist, pacman_hit,
    input  game_started, freeze, show_ready, show_won, show_lost, lives, state_dbg
  );
  modport slave (
    input  frame_tick, start_btn, pdot_exist, edot_exist, pacman_hit,
    output game_started, freeze, show_ready, show_won, show_lost, lives, state_dbg
  );
`endif

endinterface

// File: rtl/frame_timer.sv
// Frame counter for timed game states: done_c fires on the tick that completes limit+1 frames.
module frame_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  assign done_c = tick & (cnt == limit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: game state machine, lives counter and overlay/freeze controls.
// Optional pause support is enabled with the GAME_PAUSE_EN macro.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES  = DEF_START_LIVES,
  parameter int unsigned READY_FRAMES = DEF_READY_FRAMES,
  parameter int unsigned DYING_FRAMES = DEF_DYING_FRAMES,
  parameter int unsigned END_FRAMES   = DEF_END_FRAMES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input logic        clk,
  input logic        resetN,
  game_flow_ctrl_if.slave io
);

  game_state_t        state, state_nxt;
  logic [LIVES_W-1:0] lives, lives_nxt;
  logic               start_q, start_rise_c;
  logic               game_started, freeze, show_ready, show_won, show_lost;
  logic               game_started_nxt, freeze_nxt, show_ready_nxt, show_won_nxt, show_lost_nxt;
  logic               timer_tick_c, timer_clear_c, timer_done_c;
  logic [CNT_W-1:0]   timer_limit_c;
`ifdef GAME_PAUSE_EN
  logic               pause_q, pause_rise_c;
  assign pause_rise_c = io.pause_btn & ~pause_q;
`endif

  assign start_rise_c  = io.start_btn & ~start_q;
  assign timer_clear_c = (state_nxt != state);
  // Only timed states advance the counter, so PAUSED naturally holds it
  assign timer_tick_c  = io.frame_tick & (state inside {ST_READY, ST_DYING, ST_WON, ST_LOST});

  always_comb begin
    timer_limit_c = '0;
    case (state)
      ST_READY:        timer_limit_c = CNT_W'(READY_FRAMES - 1);
      ST_DYING:        timer_limit_c = CNT_W'(DYING_FRAMES - 1);
      ST_WON, ST_LOST: timer_limit_c = CNT_W'(END_FRAMES - 1);
      default:         timer_limit_c = '0;
    endcase
  end

  frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (timer_clear_c),
    .tick   (timer_tick_c),
    .limit  (timer_limit_c),
    .done_c (timer_done_c)
  );

  // Next-state, lives and output decode; outputs follow the next state
  always_comb begin
    state_nxt        = state;
    lives_nxt        = lives;
    game_started_nxt = 1'b0;
    freeze_nxt       = 1'b1;
    show_ready_nxt   = 1'b0;
    show_won_nxt     = 1'b0;
    show_lost_nxt    = 1'b0;

    case (state)
      ST_TITLE: begin
        if (start_rise_c) begin
          state_nxt = ST_READY;
          lives_nxt = LIVES_W'(START_LIVES);
        end
      end
      ST_READY: begin
        if (timer_done_c) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (!io.pdot_exist && !io.edot_exist) begin
          state_nxt = ST_WON;
        end else if (io.pacman_hit) begin
          state_nxt = ST_DYING;
          lives_nxt = (lives == '0) ? '0 : lives - LIVES_W'(1);
        end
`ifdef GAME_PAUSE_EN
        else if (pause_rise_c) begin
          state_nxt = ST_PAUSED;
        end
`endif
      end
      ST_DYING: begin
        if (timer_done_c) state_nxt = (lives == '0) ? ST_LOST : ST_READY;
      end
      ST_WON, ST_LOST: begin
        if (start_rise_c || timer_done_c) state_nxt = ST_TITLE;
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (pause_rise_c) state_nxt = ST_PLAY;
      end
`endif
      default: state_nxt = ST_TITLE;
    endcase

    game_started_nxt = (state_nxt inside {ST_READY, ST_PLAY, ST_DYING, ST_PAUSED});
    freeze_nxt       = (state_nxt != ST_PLAY);
    show_ready_nxt   = (state_nxt == ST_READY);
    show_won_nxt     = (state_nxt == ST_WON);
    show_lost_nxt    = (state_nxt == ST_LOST);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_TITLE;
      lives        <= '0;
      start_q      <= 1'b0;
      game_started <= 1'b0;
      freeze       <= 1'b1;
      show_ready   <= 1'b0;
      show_won     <= 1'b0;
      show_lost    <= 1'b0;
    end else begin
      state        <= state_nxt;
      lives        <= lives_nxt;
      start_q      <= io.start_btn;
      game_started <= game_started_nxt;
      freeze       <= freeze_nxt;
      show_ready   <= show_ready_nxt;
      show_won     <= show_won_nxt;
      show_lost    <= show_lost_nxt;
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pause_q <= 1'b0;
    else         pause_q <= io.pause_btn;
  end
`endif

  assign io.game_started = game_started;
  assign io.freeze       = freeze;
  assign io.show_ready   = show_ready;
  assign io.show_won     = show_won;
  assign io.show_lost    = show_lost;
  assign io.lives        = lives;
  assign io.state_dbg    = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game scenarios then random play, against a frames-remaining model.
module tb_game_flow_ctrl;

  localparam int T_LIVES = 3;
  localparam int T_READY = 4;
  localparam int T_DYING = 3;
  localparam int T_END   = 5;
  localparam int T_CNT_W = 4;

  localparam int M_TITLE = 0, M_READY = 1, M_PLAY = 2, M_DYING = 3,
                 M_WON = 4, M_LOST = 5, M_PAUSED = 6;

  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   ms, ml, mrem;
  logic mprev_start, mprev_pause;

  game_flow_ctrl_if io ();

  game_flow_ctrl #(
    .START_LIVES  (T_LIVES),
    .READY_FRAMES (T_READY),
    .DYING_FRAMES (T_DYING),
    .END_FRAMES   (T_END),
    .CNT_W        (T_CNT_W)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .io     (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frames_of(input int s);
    case (s)
      M_READY:       return T_READY;
      M_DYING:       return T_DYING;
      M_WON, M_LOST: return T_END;
      default:       return 0;
    endcase
  endfunction

  // One clock of game rules; timed states count frames remaining down from their length
  task automatic model_step();
    int   ns, nl;
    logic srise, prise, expired;
    srise = io.start_btn && !mprev_start;
    mprev_start = io.start_btn;
`ifdef GAME_PAUSE_EN
    prise = io.pause_btn && !mprev_pause;
    mprev_pause = io.pause_btn;
`else
    prise = 1'b0;
`endif
    ns = ms; nl = ml;
    expired = 1'b0;
    if (io.frame_tick && frames_of(ms) > 0) begin
      if (mrem == 1) expired = 1'b1;
      else mrem = mrem - 1;
    end
    case (ms)
      M_TITLE:  if (srise) begin ns = M_READY; nl = T_LIVES; end
      M_READY:  if (expired) ns = M_PLAY;
      M_PLAY: begin
        if (!io.pdot_exist && !io.edot_exist) ns = M_WON;
        else if (io.pacman_hit) begin ns = M_DYING; nl = (ml > 0) ? ml - 1 : 0; end
        else if (prise) ns = M_PAUSED;
      end
      M_DYING:  if (expired) ns = (ml == 0) ? M_LOST : M_READY;
      M_WON, M_LOST: if (srise || expired) ns = M_TITLE;
      M_PAUSED: if (prise) ns = M_PLAY;
      default:  ns = M_TITLE;
    endcase
    if (ns != ms) mrem = frames_of(ns);
    ms = ns; ml = nl;
  endtask

  task automatic model_reset();
    ms = M_TITLE; ml = 0; mrem = 0;
    mprev_start = 1'b0; mprev_pause = 1'b0;
  endtask

  task automatic check_all();
    chk("state",   io.state_dbg,    8'(ms));
    chk("lives",   io.lives,        8'(ml));
    chk("freeze",  io.freeze,       8'(ms != M_PLAY));
    chk("started", io.game_started, 8'(ms inside {M_READY, M_PLAY, M_DYING, M_PAUSED}));
    chk("ready",   io.show_ready,   8'(ms == M_READY));
    chk("won",     io.show_won,     8'(ms == M_WON));
    chk("lost",    io.show_lost,    8'(ms == M_LOST));
  endtask

  task automatic step(input logic t, input logic h);
    io.frame_tick = t;
    io.pacman_hit = h;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    io.frame_tick = 1'b0;
    io.pacman_hit = 1'b0;
  endtask

  task automatic set_dots(input logic v);
    io.pdot_exist = v;
    io.edot_exist = v;
  endtask

  task automatic start_game();
    io.start_btn = 1'b1; step(1'b0, 1'b0);
    io.start_btn = 1'b0; step(1'b0, 1'b0);
    repeat (T_READY) step(1'b1, 1'b0);
  endtask

  initial begin
    resetN = 1'b0;
    io.frame_tick = 1'b0; io.start_btn = 1'b0; io.pacman_hit = 1'b0;
    set_dots(1'b1);
`ifdef GAME_PAUSE_EN
    io.pause_btn = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",  io.state_dbg, 8'd0);
    chk("rst_lives",  io.lives,     8'd0);
    chk("rst_freeze", io.freeze,    8'd1);
    check_all();
    resetN = 1'b1;

    // Held start produces a single TITLE->READY event
    io.start_btn = 1'b1;
    repeat (50) step(1'b0, 1'b0);
    chk("tp_start_state", io.state_dbg,  8'd1);
    chk("tp_start_lives", io.lives,      8'd3);
    chk("tp_start_ready", io.show_ready, 8'd1);
    io.start_btn = 1'b0;
    step(1'b0, 1'b1);
    repeat (T_READY - 1) step(1'b1, 1'b0);
    chk("tp_ready_hold", io.state_dbg, 8'd1);
    step(1'b1, 1'b0);
    chk("tp_play_state",  io.state_dbg,  8'd2);
    chk("tp_play_freeze", io.freeze,     8'd0);
    chk("tp_play_ready",  io.show_ready, 8'd0);

    for (int k = T_LIVES; k > 0; k--) begin
      step(1'b0, 1'b1);
      chk("tp_hit_state", io.state_dbg, 8'd3);
      chk("tp_hit_lives", io.lives, 8'(k - 1));
      repeat (T_DYING) step(1'b1, 1'b0);
      if (k > 1) repeat (T_READY) step(1'b1, 1'b0);
    end
    chk("tp_lost_state",   io.state_dbg,    8'd5);
    chk("tp_lost_show",    io.show_lost,    8'd1);
    chk("tp_lost_started", io.game_started, 8'd0);
    repeat (T_END - 1) step(1'b1, 1'b0);
    chk("tp_lost_hold", io.state_dbg, 8'd5);
    step(1'b1, 1'b0);
    chk("tp_lost_exit", io.state_dbg, 8'd0);

    // Win beats a simultaneous hit; start cuts the end screen short
    start_game();
    set_dots(1'b0);
    step(1'b0, 1'b1);
    set_dots(1'b1);
    chk("tp_won_state", io.state_dbg, 8'd4);
    chk("tp_won_lives", io.lives,     8'd3);
    chk("tp_won_show",  io.show_won,  8'd1);
    step(1'b1, 1'b0);
    io.start_btn = 1'b1; step(1'b0, 1'b0);
    chk("tp_won_start", io.state_dbg, 8'd0);
    chk("tp_title_lives_kept", io.lives, 8'd3);
    io.start_btn = 1'b0; step(1'b0, 1'b0);

    start_game();
    set_dots(1'b0); step(1'b0, 1'b0); set_dots(1'b1);
    repeat (T_END) step(1'b1, 1'b0);
    chk("tp_won_timeout", io.state_dbg, 8'd0);
    chk("tp_won_cleared", io.show_won,  8'd0);

`ifdef GAME_PAUSE_EN
    start_game();
    io.pause_btn = 1'b1; step(1'b0, 1'b0);
    chk("tp_paused", io.state_dbg, 8'd6);
    io.pause_btn = 1'b0;
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    io.pause_btn = 1'b1; step(1'b0, 1'b0);
    io.pause_btn = 1'b0;
    chk("tp_resumed", io.state_dbg, 8'd2);
    step(1'b0, 1'b1);
    repeat (T_DYING) step(1'b1, 1'b0);
    repeat (T_READY) step(1'b1, 1'b0);
`else
    start_game();
`endif

    // Asynchronous reset in the middle of DYING
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("tp_dying_pre", io.state_dbg, 8'd3);
    #2 resetN = 1'b0;
    #1;
    chk("tp_arst_state",  io.state_dbg, 8'd0);
    chk("tp_arst_lives",  io.lives,     8'd0);
    chk("tp_arst_freeze", io.freeze,    8'd1);
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    check_all();

    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(7) == 0) io.start_btn = ~io.start_btn;
`ifdef GAME_PAUSE_EN
      if ($urandom_range(11) == 0) io.pause_btn = ~io.pause_btn;
`endif
      r = int'($urandom_range(39));
      io.pdot_exist = (r != 0);
      io.edot_exist = (r != 0) && (r != 1);
      step($urandom_range(3) == 0, $urandom_range(9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
